// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write-side FIFO. Frames go out LSB-first, back-to-back,
// one bit per external baud tick, with parity and stop-bit count latched per frame.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   localparam int CW = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   output logic                 tx,
   output logic                 busy,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic [CW:0]          fifo_count,
   output logic                 overflow,
   output logic                 tx_done
);

   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
   localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2} state_t;

   state_t               state, state_nx;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [CW-1:0]        wr_ptr, rd_ptr;
   logic [CW:0]          count;
   logic [DATA_BITS-1:0] shift_reg, head;
   logic [IW-1:0]        bit_idx;
   logic                 par_bit, cfg_pe, cfg_ts;
   logic                 tx_nx, pop, do_wr, frame_end, idx_clr, idx_inc, shift_en;

   assign head       = mem[rd_ptr];
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_C);
   assign fifo_count = count;
   assign busy       = (state != IDLE) || !fifo_empty;
   // Fullness is judged before any same-cycle pop, so a write while full is always dropped.
   assign do_wr      = wr_en && !fifo_full;
   assign overflow   = wr_en && fifo_full && !rst;
   assign tx_done    = frame_end && !rst;

   always_comb begin
      state_nx  = state;
      tx_nx     = tx;
      pop       = 1'b0;
      frame_end = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      shift_en  = 1'b0;
      case (state)
         IDLE:   if (!fifo_empty) begin pop = 1'b1; state_nx = LOAD; end
         LOAD:   if (baud_tick) begin tx_nx = 1'b0; state_nx = START; end
         START:  if (baud_tick) begin tx_nx = shift_reg[0]; idx_clr = 1'b1; state_nx = DATA; end
         DATA:
            if (baud_tick) begin
               if (bit_idx != LAST_IDX) begin
                  idx_inc  = 1'b1;
                  shift_en = 1'b1;
                  tx_nx    = shift_reg[1];
               end else if (cfg_pe) begin
                  tx_nx    = par_bit;
                  state_nx = PARITY;
               end else begin
                  tx_nx    = 1'b1;
                  state_nx = STOP1;
               end
            end
         PARITY: if (baud_tick) begin tx_nx = 1'b1; state_nx = STOP1; end
         STOP1:
            if (baud_tick) begin
               if (cfg_ts) begin tx_nx = 1'b1; state_nx = STOP2; end
               else frame_end = 1'b1;
            end
         STOP2:  if (baud_tick) frame_end = 1'b1;
         default: state_nx = IDLE;
      endcase
      // The tick ending a frame doubles as the start bit of the next queued word.
      if (frame_end) begin
         if (!fifo_empty) begin
            pop      = 1'b1;
            tx_nx    = 1'b0;
            state_nx = START;
         end else begin
            tx_nx    = 1'b1;
            state_nx = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         shift_reg <= '0;
         bit_idx   <= '0;
         par_bit   <= 1'b0;
         cfg_pe    <= 1'b0;
         cfg_ts    <= 1'b0;
      end else begin
         state <= state_nx;
         tx    <= tx_nx;
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            shift_reg <= head;
            par_bit   <= ^head ^ parity_odd;
            cfg_pe    <= parity_en;
            cfg_ts    <= two_stop;
         end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
         end
         case ({do_wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (idx_clr)      bit_idx <= '0;
         else if (idx_inc) bit_idx <= bit_idx + 1'b1;
      end
   end

endmodule
